serpent_de_iter: RTL and testbench

// Iterative Serpent block decryptor. It is the inverse counterpart of the

---
 rtl/serpent_de_iter.sv | 164 ++++++++++++++++
 tb/tb_serpent_de_iter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serpent_de_iter.sv
// Iterative Serpent block decryptor: one inverse round per clock, subkeys
// fetched by index from an external key-schedule store, one block in flight.
module serpent_de_iter #(
  parameter  int unsigned ROUNDS = 32,
  localparam int unsigned BW     = 128,
  localparam int unsigned WW     = 32,
  localparam int unsigned KW     = 6
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [BW-1:0] i_data,
  output logic [KW-1:0] o_key_idx,
  input  logic [BW-1:0] i_subkey,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [BW-1:0] o_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] INIT  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Forward S-boxes, entry i at bits [4*i +: 4]; inverses are found by search.
  localparam logic [63:0] SBOX [8] = '{
    64'hC90724DEB56A1F83, 64'h43D68EB1A50972CF,
    64'h25B04E1DFAC39768, 64'hE57A421D369C8BF0,
    64'hD7E9A4526B0C38F1, 64'h176D8E30C9A4B25F,
    64'h0A3DF19EB6485C27, 64'h6539AC47B28E0FD1
  };

  logic [1:0]    state, state_nxt;
  logic [BW-1:0] d, d_nxt;
  logic [KW-1:0] r, r_nxt;
  logic [KW-1:0] key_nxt;
  logic          valid_nxt, ready_nxt;
  logic [BW-1:0] data_nxt;
  logic [BW-1:0] round_in, round_out;

  function automatic logic [WW-1:0] rotr(input logic [WW-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WW - n));
  endfunction

  function automatic logic [3:0] inv_nib(input logic [2:0] b, input logic [3:0] y);
    logic [63:0] t;
    logic [3:0]  res;
    t   = SBOX[b];
    res = '0;
    for (int i = 0; i < 16; i++) begin
      if (t[4*i +: 4] == y) res = 4'(i);
    end
    return res;
  endfunction

  // Inverse S-box applied to every bit column across the four words
  function automatic logic [BW-1:0] inv_sbox(input logic [2:0] b, input logic [BW-1:0] x);
    logic [BW-1:0] y;
    logic [3:0]    n;
    logic [3:0]    m;
    y = '0;
    for (int j = 0; j < 32; j++) begin
      n = {x[96+j], x[64+j], x[32+j], x[j]};
      m = inv_nib(b, n);
      y[j]    = m[0];
      y[32+j] = m[1];
      y[64+j] = m[2];
      y[96+j] = m[3];
    end
    return y;
  endfunction

  // Inverse linear transform: encrypt steps undone in reverse order
  function automatic logic [BW-1:0] inv_lt(input logic [BW-1:0] x);
    logic [WW-1:0] x0, x1, x2, x3;
    x0 = x[31:0];
    x1 = x[63:32];
    x2 = x[95:64];
    x3 = x[127:96];
    x2 = rotr(x2, 22);
    x0 = rotr(x0, 5);
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = x0 ^ x1 ^ x3;
    x3 = rotr(x3, 7);
    x1 = rotr(x1, 1);
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = x1 ^ x0 ^ x2;
    x2 = rotr(x2, 3);
    x0 = rotr(x0, 13);
    return {x3, x2, x1, x0};
  endfunction

  // Round datapath; the last encrypt round had no LT, so the first inverse round skips it
  assign round_in  = (r == KW'(ROUNDS - 1)) ? d : inv_lt(d);
  assign round_out = inv_sbox(r[2:0], round_in) ^ i_subkey;

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    d_nxt     = d;
    r_nxt     = r;
    key_nxt   = o_key_idx;
    valid_nxt = o_valid;
    ready_nxt = o_ready;
    data_nxt  = o_data;
    case (state)
      IDLE: begin
        if (i_valid) begin
          d_nxt     = i_data;
          ready_nxt = 1'b0;
          state_nxt = INIT;
        end
      end
      INIT: begin
        d_nxt     = d ^ i_subkey;
        r_nxt     = KW'(ROUNDS - 1);
        key_nxt   = KW'(ROUNDS - 1);
        state_nxt = ROUND;
      end
      ROUND: begin
        d_nxt = round_out;
        if (r == '0) begin
          data_nxt  = round_out;
          valid_nxt = 1'b1;
          key_nxt   = KW'(ROUNDS);
          state_nxt = DONE;
        end else begin
          r_nxt   = r - KW'(1);
          key_nxt = r - KW'(1);
        end
      end
      default: begin
        if (i_ready) begin
          valid_nxt = 1'b0;
          ready_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      d         <= '0;
      r         <= '0;
      o_key_idx <= KW'(ROUNDS);
      o_valid   <= 1'b0;
      o_ready   <= 1'b1;
      o_data    <= '0;
    end else begin
      state     <= state_nxt;
      d         <= d_nxt;
      r         <= r_nxt;
      o_key_idx <= key_nxt;
      o_valid   <= valid_nxt;
      o_ready   <= ready_nxt;
      o_data    <= data_nxt;
    end
  end

endmodule

// File: tb/tb_serpent_de_iter.sv
// Bench for serpent_de_iter: forward-cipher model plus scoreboard.
module tb_serpent_de_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         s_valid, s_ready, m_valid, m_ready;
  logic [127:0] s_data, m_data, subkey;
  logic [5:0]   key_idx;

  logic         s_valid1, s_ready1, m_valid1, m_ready1;
  logic [127:0] s_data1, m_data1, subkey1;
  logic [5:0]   key_idx1;

  logic [127:0] ks [33];
  logic [127:0] exp_q [$];
  int           acc_q [$];
  int           cyc = 0;
  int           n_vec = 0;
  int           n_bad = 0;

  assign subkey  = (key_idx <= 6'd32) ? ks[key_idx] : '0;
  assign subkey1 = '0;

  serpent_de_iter #(.ROUNDS(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(s_valid), .o_ready(s_ready),
    .i_data(s_data), .o_key_idx(key_idx), .i_subkey(subkey),
    .o_valid(m_valid), .i_ready(m_ready), .o_data(m_data));

  serpent_de_iter #(.ROUNDS(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(s_valid1), .o_ready(s_ready1),
    .i_data(s_data1), .o_key_idx(key_idx1), .i_subkey(subkey1),
    .o_valid(m_valid1), .i_ready(m_ready1), .o_data(m_data1));

  int unsigned sb [8][16] = '{
    '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
    '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
    '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
    '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
    '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
    '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
    '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
    '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
  };

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] fwd_s(input int b, input logic [127:0] x);
    logic [127:0] y;
    logic [3:0]   n, m;
    y = '0;
    for (int j = 0; j < 32; j++) begin
      n = {x[96+j], x[64+j], x[32+j], x[j]};
      m = 4'(sb[b][n]);
      y[j] = m[0]; y[32+j] = m[1]; y[64+j] = m[2]; y[96+j] = m[3];
    end
    return y;
  endfunction

  function automatic logic [127:0] lt(input logic [127:0] x);
    logic [31:0] x0, x1, x2, x3;
    x0 = x[31:0]; x1 = x[63:32]; x2 = x[95:64]; x3 = x[127:96];
    x0 = rotl(x0, 13);
    x2 = rotl(x2, 3);
    x1 = x1 ^ x0 ^ x2;
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = rotl(x1, 1);
    x3 = rotl(x3, 7);
    x0 = x0 ^ x1 ^ x3;
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rotl(x0, 5);
    x2 = rotl(x2, 22);
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] p);
    logic [127:0] b;
    b = p;
    for (int i = 0; i < 32; i++) begin
      b = fwd_s(i % 8, b ^ ks[i]);
      if (i < 31) b = lt(b);
      else        b = b ^ ks[32];
    end
    return b;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // Present a block; returns one tick after the accept edge
  task automatic send(input logic [127:0] c, input logic [127:0] p, input bit keep);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = c;
    while (!s_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) timeout("send_ready");
    exp_q.push_back(p);
    @(posedge clk); #1;
    if (!keep) s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) timeout("drain");
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Record accept cycles
  always @(negedge clk) begin
    if (rst_n && s_valid && s_ready) acc_q.push_back(cyc);
  end

  // Scoreboard monitor: compare on each output handshake
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_unexpected: got %h expected no output", m_data);
      end else begin
        chk("sb_plaintext", m_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] p;
    int           n;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    s_valid1 = 1'b0; s_data1 = '0; m_ready1 = 1'b0;
    for (int i = 0; i < 33; i++) ks[i] = rnd128();

    // Reset state
    @(posedge clk); #1;
    chk("rst_ready", 128'(s_ready), 128'(1));
    chk("rst_valid", 128'(m_valid), 128'(0));
    chk("rst_data", m_data, '0);
    chk("rst_key", 128'(key_idx), 128'(32));
    chk("rst_key_r1", 128'(key_idx1), 128'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ROUNDS=1, zero keys, zero ciphertext: every column decrypts to 0xD
    s_valid1 = 1'b1;
    @(posedge clk); #1;
    s_valid1 = 1'b0;
    chk("r1_valid_c1", 128'(m_valid1), 128'(0));
    @(posedge clk); #1;
    chk("r1_valid_c2", 128'(m_valid1), 128'(0));
    @(posedge clk); #1;
    chk("r1_valid_lat", 128'(m_valid1), 128'(1));
    chk("r1_data", m_data1, 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF);
    m_ready1 = 1'b1;
    @(posedge clk); #1;
    chk("r1_release", 128'(s_ready1), 128'(1));

    // Key fetch order and latency
    p = rnd128();
    send(enc(p), p, 1'b0);
    for (int k = 0; k <= 33; k++) begin
      chk("key_order", 128'(key_idx), 128'((k == 0 || k == 33) ? 32 : 32 - k));
      if (k == 32) chk("lat_not_yet", 128'(m_valid), 128'(0));
      if (k == 33) chk("lat_valid", 128'(m_valid), 128'(1));
      @(posedge clk); #1;
    end
    drain();

    // Round trip, i_valid held high back-to-back
    acc_q.delete();
    for (int i = 0; i < 50; i++) begin
      p = rnd128();
      send(enc(p), p, (i < 49));
    end
    drain();
    chk("accept_count", 128'(acc_q.size()), 128'(50));
    if (acc_q.size() == 50) begin
      for (int i = 1; i < 50; i++) chk("issue_interval", 128'(acc_q[i] - acc_q[i-1]), 128'(35));
    end

    // Backpressure in DONE
    m_ready = 1'b0;
    p = rnd128();
    send(enc(p), p, 1'b0);
    n = 0;
    while (!m_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_valid) timeout("bp_valid_wait");
    s_valid = 1'b1;
    s_data  = rnd128();
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", 128'(m_valid), 128'(1));
      chk("bp_data", m_data, p);
      chk("bp_ready", 128'(s_ready), 128'(0));
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_ready", 128'(s_ready), 128'(1));
    chk("bp_rel_valid", 128'(m_valid), 128'(0));
    chk("bp_sb_empty", 128'(exp_q.size()), 128'(0));

    // Reset in the middle of a block
    p = rnd128();
    send(enc(p), p, 1'b0);
    repeat (15) begin
      @(posedge clk); #1;
    end
    chk("mr_key_before", 128'(key_idx), 128'(17));
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 128'(m_valid), 128'(0));
    chk("mr_ready", 128'(s_ready), 128'(1));
    chk("mr_key", 128'(key_idx), 128'(32));
    chk("mr_data", m_data, '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    p = rnd128();
    send(enc(p), p, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
